// File: rtl/dense_neuron_mac_pkg.sv
// Shared definitions for the MNIST dense-layer neuron datapath.
//   - default activation/weight and bias/result widths
//   - neuron controller state enumeration
//   - saturation bounds for the signed result (default width), plus helpers
//     that give the same bounds for any result width
package mnist_pkg;

  localparam int DEF_WEIGHTS_WIDTH = 8;
  localparam int DEF_BIAS_WIDTH    = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    BIAS,
    DONE
  } neuron_state_t;

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(DEF_BIAS_WIDTH);
  localparam longint SAT_MIN = sat_min(DEF_BIAS_WIDTH);

endpackage

// File: rtl/dense_neuron_mac_if.sv
// Caller/RAM-facing bundle of the dense neuron MAC.
//   start    : request one neuron computation
//   busy     : computation in progress
//   done     : one-cycle pulse, acc_out valid
//   rd_en    : read enable to activation and weight RAMs
//   rd_addr  : shared RAM index
//   act_data : activation read data (1-cycle RAM latency)
//   wgt_data : weight read data (1-cycle RAM latency)
//   bias     : neuron bias, stable from start until done
//   acc_out  : saturated dot product plus bias
// Modport slave is the neuron's view, master is the caller/RAM view.
interface dense_neuron_mac_if
  import mnist_pkg::*;
#(
  parameter int INPUT_SIZE    = 512,
  parameter int WEIGHTS_WIDTH = DEF_WEIGHTS_WIDTH,
  parameter int BIAS_WIDTH    = DEF_BIAS_WIDTH
);

  localparam int ADDR_W = $clog2(INPUT_SIZE);

  logic                            start;
  logic                            busy;
  logic                            done;
  logic                            rd_en;
  logic        [ADDR_W-1:0]        rd_addr;
  logic signed [WEIGHTS_WIDTH-1:0] act_data;
  logic signed [WEIGHTS_WIDTH-1:0] wgt_data;
  logic signed [BIAS_WIDTH-1:0]    bias;
  logic signed [BIAS_WIDTH-1:0]    acc_out;

  modport slave (
    input  start, act_data, wgt_data, bias,
    output busy, done, rd_en, rd_addr, acc_out
  );

  modport master (
    output start, act_data, wgt_data, bias,
    input  busy, done, rd_en, rd_addr, acc_out
  );

endinterface

// File: rtl/dense_neuron_mac_mac_pipe.sv
// Three-stage multiply-accumulate pipeline.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear of accumulator and pipeline
//   in_valid   : act/wgt carry a valid operand pair this cycle
//   act, wgt   : signed operands
//   acc        : running signed sum of products
// Stages: operand register, registered full-width product, sign-extended
// accumulate. The accumulator is wide enough that it never wraps.
module mac_pipe
  import mnist_pkg::*;
#(
  parameter int WEIGHTS_WIDTH = DEF_WEIGHTS_WIDTH,
  parameter int ACC_W         = DEF_BIAS_WIDTH + 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            in_valid,
  input  logic signed [WEIGHTS_WIDTH-1:0] act,
  input  logic signed [WEIGHTS_WIDTH-1:0] wgt,
  output logic signed [ACC_W-1:0]         acc
);

  localparam int PROD_W = 2 * WEIGHTS_WIDTH;

  logic signed [WEIGHTS_WIDTH-1:0] act_q;
  logic signed [WEIGHTS_WIDTH-1:0] wgt_q;
  logic                            op_vld_q;
  logic signed [PROD_W-1:0]        prod_q;
  logic                            prod_vld_q;
  logic signed [ACC_W-1:0]         acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      act_q      <= '0;
      wgt_q      <= '0;
      op_vld_q   <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      op_vld_q <= in_valid;
      if (in_valid) begin
        act_q <= act;
        wgt_q <= wgt;
      end
      prod_vld_q <= op_vld_q;
      prod_q     <= PROD_W'(act_q) * PROD_W'(wgt_q);
      if (prod_vld_q) begin
        acc_q <= acc_q + ACC_W'(prod_q);
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dense_neuron_mac.sv
// Dense-layer neuron: dot product of INPUT_SIZE activations and weights read
// from two RAMs through a shared index, plus bias, saturated to BIAS_WIDTH.
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : slave view of dense_neuron_mac_if (start/busy/done handshake,
//           RAM read port, bias in, acc_out result)
// done rises INPUT_SIZE+5 edges after the edge that accepted start; acc_out
// only changes on that edge.
module dense_neuron_mac
  import mnist_pkg::*;
#(
  parameter int INPUT_SIZE    = 512,
  parameter int WEIGHTS_WIDTH = DEF_WEIGHTS_WIDTH,
  parameter int BIAS_WIDTH    = DEF_BIAS_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  dense_neuron_mac_if.slave bus
);

  localparam int ADDR_W = $clog2(INPUT_SIZE);
  localparam int ACC_W  = BIAS_WIDTH + 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INPUT_SIZE - 1);

  // Default-width bounds come from the package; other widths use its helpers.
  localparam logic signed [ACC_W-1:0] ACC_HI =
    (BIAS_WIDTH == DEF_BIAS_WIDTH) ? ACC_W'(SAT_MAX) : ACC_W'(sat_max(BIAS_WIDTH));
  localparam logic signed [ACC_W-1:0] ACC_LO =
    (BIAS_WIDTH == DEF_BIAS_WIDTH) ? ACC_W'(SAT_MIN) : ACC_W'(sat_min(BIAS_WIDTH));

  neuron_state_t state_q, state_d;

  logic [1:0]              drain_q, drain_d;
  logic                    rd_en_q, rd_en_d;
  logic                    rd_vld_q;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    clr;
  logic                    load_sum;
  logic                    load_out;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_q;
  logic signed [ACC_W-1:0] sat_w;
  logic signed [BIAS_WIDTH-1:0] acc_out_q;

  mac_pipe #(
    .WEIGHTS_WIDTH (WEIGHTS_WIDTH),
    .ACC_W         (ACC_W)
  ) u_mac_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (rd_vld_q),
    .act      (bus.act_data),
    .wgt      (bus.wgt_data),
    .acc      (acc)
  );

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    clr       = 1'b0;
    load_sum  = 1'b0;
    load_out  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr       = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (rd_addr_q == LAST_ADDR) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Last read: RAM latency, operand register, product register, then
        // the accumulate edge lands as DRAIN hands over to BIAS.
        if (drain_q == 2'd2) begin
          state_d = BIAS;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      BIAS: begin
        load_sum = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        load_out = 1'b1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sat_w = sum_q;
    if (sum_q > ACC_HI) begin
      sat_w = ACC_HI;
    end else if (sum_q < ACC_LO) begin
      sat_w = ACC_LO;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      acc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      rd_en_q   <= rd_en_d;
      rd_vld_q  <= rd_en_q;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (load_sum) begin
        sum_q <= acc + ACC_W'(bus.bias);
      end
      if (load_out) begin
        acc_out_q <= BIAS_WIDTH'(sat_w);
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.acc_out = acc_out_q;

endmodule

// File: tb/tb_dense_neuron_mac.sv
// Bench for dense_neuron_mac: a 4-input and a 512-input instance share clock
// and reset. A transaction-level model predicts each neuron's outputs from
// the RAM contents and bias captured at the accepting edge; one compare
// process checks every output of both instances every cycle.
module tb_dense_neuron_mac;

  localparam int     N_SMALL = 4;
  localparam int     N_LARGE = 512;
  localparam longint MAX32   = 64'sd2147483647;
  localparam longint MIN32   = -64'sd2147483648;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dense_neuron_mac_if #(.INPUT_SIZE(N_SMALL)) bs ();
  dense_neuron_mac_if #(.INPUT_SIZE(N_LARGE)) bl ();

  dense_neuron_mac #(.INPUT_SIZE(N_SMALL)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bs.slave)
  );

  dense_neuron_mac #(.INPUT_SIZE(N_LARGE)) dut_large (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bl.slave)
  );

  int     act_mem [2][N_LARGE];
  int     wgt_mem [2][N_LARGE];
  int     cyc     [2] = '{-1, -1};
  longint held    [2] = '{0, 0};
  longint pend    [2] = '{0, 0};
  int     nreads  [2] = '{0, 0};
  int     n_checks = 0;
  int     n_pass   = 0;

  // Activation/weight RAMs with one cycle read latency.
  always @(posedge clk) begin
    if (bs.rd_en) begin
      bs.act_data <= 8'(act_mem[0][bs.rd_addr]);
      bs.wgt_data <= 8'(wgt_mem[0][bs.rd_addr]);
    end
    if (bl.rd_en) begin
      bl.act_data <= 8'(act_mem[1][bl.rd_addr]);
      bl.wgt_data <= 8'(wgt_mem[1][bl.rd_addr]);
    end
  end

  task automatic chk(input string nm, input int d, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", nm, d, $time, got, exp);
  endtask

  function automatic longint ref_result(input int d, input int n, input longint b);
    longint s = b;
    for (int i = 0; i < n; i++) s += longint'(act_mem[d][i]) * longint'(wgt_mem[d][i]);
    if (s > MAX32) s = MAX32;
    else if (s < MIN32) s = MIN32;
    return s;
  endfunction

  // cyc = edges since the accepting edge, -1 when free to accept.
  task automatic model_step(input int d, input int n, input logic st, input longint bv,
                            input logic dn, input logic bz, input logic re,
                            input int addr, input longint acc);
    logic done_now;
    done_now = 1'b0;
    if (!rst_n) begin
      cyc[d]  = -1;
      held[d] = 0;
      chk("rst_done", d, longint'(dn), 0);
      chk("rst_busy", d, longint'(bz), 0);
      chk("rst_rd_en", d, longint'(re), 0);
      chk("rst_rd_addr", d, longint'(addr), 0);
      chk("rst_acc_out", d, acc, 0);
      return;
    end
    if (cyc[d] < 0) begin
      if (st) begin
        cyc[d]  = 0;
        pend[d] = ref_result(d, n, bv);
      end
    end else begin
      cyc[d]++;
      if (cyc[d] == n + 5) begin
        done_now = 1'b1;
        held[d]  = pend[d];
      end
    end
    if (re) nreads[d]++;
    chk("done", d, longint'(dn), longint'(done_now));
    chk("busy", d, longint'(bz), longint'(cyc[d] >= 0 && !done_now));
    chk("rd_en", d, longint'(re), longint'(cyc[d] >= 0 && cyc[d] < n));
    if (cyc[d] >= 0 && cyc[d] < n) chk("rd_addr", d, longint'(addr), longint'(cyc[d]));
    chk("acc_out", d, acc, held[d]);
    if (done_now) cyc[d] = -1;
  endtask

  always @(posedge clk) begin
    #1;
    model_step(0, N_SMALL, bs.start, longint'(bs.bias), bs.done, bs.busy, bs.rd_en,
               int'(bs.rd_addr), longint'(bs.acc_out));
    model_step(1, N_LARGE, bl.start, longint'(bl.bias), bl.done, bl.busy, bl.rd_en,
               int'(bl.rd_addr), longint'(bl.acc_out));
  end

  task automatic launch(input int d);
    @(negedge clk);
    if (d == 0) bs.start = 1'b1; else bl.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (d == 0) bs.start = 1'b0; else bl.start = 1'b0;
  endtask

  // Edges after the accepting edge until done, or -1 if the limit expires.
  task automatic wait_done(input int d, input int limit, output int edges);
    logic got;
    got   = 1'b0;
    edges = 0;
    while (edges < limit && !got) begin
      @(posedge clk);
      #2;
      edges++;
      got = (d == 0) ? bs.done : bl.done;
    end
    if (!got) edges = -1;
  endtask

  task automatic run_small(input int a0, input int a1, input int a2, input int a3,
                           input int w, input logic [31:0] b, input longint lit);
    int e;
    act_mem[0][0] = a0; act_mem[0][1] = a1; act_mem[0][2] = a2; act_mem[0][3] = a3;
    for (int i = 0; i < N_SMALL; i++) wgt_mem[0][i] = w;
    bs.bias = b;
    launch(0);
    wait_done(0, 40, e);
    chk("done_edge", 0, longint'(e), 9);
    chk("acc_literal", 0, longint'(bs.acc_out), lit);
    chk("model_literal", 0, held[0], lit);
  endtask

  task automatic fill_rand(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      act_mem[d][i] = int'($urandom_range(0, 255)) - 128;
      wgt_mem[d][i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic run_small_rand();
    int e;
    fill_rand(0, N_SMALL);
    case ($urandom_range(0, 3))
      0:       bs.bias = 32'(int'($urandom_range(0, 200000)) - 100000);
      1:       bs.bias = 32'h7FFF_C000 + 32'($urandom_range(0, 16383));
      2:       bs.bias = 32'h8000_0000 + 32'($urandom_range(0, 16383));
      default: bs.bias = $urandom;
    endcase
    launch(0);
    wait_done(0, 40, e);
    chk("done_edge_rand", 0, longint'(e), 9);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e;
    int c;
    int nd;
    int de [3];
    bs.start = 1'b0;
    bl.start = 1'b0;
    bs.bias  = '0;
    bl.bias  = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post_reset_acc", 0, longint'(bs.acc_out), 0);
    chk("post_reset_busy", 1, longint'(bl.busy), 0);

    // Directed neurons with hand-computed results.
    run_small(1, 2, 3, 4, 1, 32'd10, 20);
    run_small(-128, -128, -128, -128, 127, 32'd0, -65024);
    run_small(127, 127, 127, 127, 127, 32'h7FFF_FFF0, MAX32);
    run_small(-128, -128, -128, -128, 127, 32'h8000_0000, MIN32);

    // Abort during the second fetch cycle.
    fill_rand(0, N_SMALL);
    @(negedge clk) bs.start = 1'b1;
    @(posedge clk);
    @(negedge clk) bs.start = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_busy", 0, longint'(bs.busy), 0);
    chk("abort_rd_en", 0, longint'(bs.rd_en), 0);
    chk("abort_acc_out", 0, longint'(bs.acc_out), 0);
    @(negedge clk) rst_n = 1'b1;
    wait_done(0, 20, e);
    chk("no_done_after_abort", 0, longint'(e), -1);

    // Start coinciding with reset is dropped.
    @(negedge clk);
    bs.start = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    bs.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("start_in_reset_busy", 0, longint'(bs.busy), 0);
    run_small_rand();

    // Start held high across three neurons.
    fill_rand(0, N_SMALL);
    bs.bias = 32'd1234;
    c  = 0;
    nd = 0;
    de = '{0, 0, 0};
    @(negedge clk) bs.start = 1'b1;
    @(posedge clk);
    while (c < 60 && nd < 3) begin
      @(posedge clk);
      #2;
      c++;
      if (bs.done) begin
        de[nd] = c;
        nd++;
      end
    end
    @(negedge clk) bs.start = 1'b0;
    chk("held_done_count", 0, longint'(nd), 3);
    chk("held_first_done", 0, longint'(de[0]), 9);
    chk("held_spacing_1", 0, longint'(de[1] - de[0]), N_SMALL + 6);
    chk("held_spacing_2", 0, longint'(de[2] - de[1]), N_SMALL + 6);
    wait_done(0, 15, e);
    chk("held_no_extra_done", 0, longint'(e), -1);

    repeat (6) run_small_rand();

    // Full-size neurons.
    for (int r = 0; r < 2; r++) begin
      fill_rand(1, N_LARGE);
      bl.bias   = (r == 0) ? $urandom : 32'h7FFF_0000;
      nreads[1] = 0;
      launch(1);
      wait_done(1, 600, e);
      chk("large_done_edge", 1, longint'(e), N_LARGE + 5);
      chk("large_read_count", 1, longint'(nreads[1]), N_LARGE);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dense_neuron_mac.md
DENSE_NEURON_MAC -- requirements
Module: dense_neuron_mac

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 512, number of int8 input activations per neuron (legal range 2..4096).
REQ-002 SHALL have parameter WEIGHTS_WIDTH, default 8, signed width of activations and weights.
REQ-003 SHALL have parameter BIAS_WIDTH, default 32, signed width of bias and result.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port start, input, 1, request to compute one neuron; sampled only in IDLE.
REQ-007 SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking acc_out valid.
REQ-009 SHALL have port rd_en, output, 1, read enable to activation and weight RAMs.
REQ-010 SHALL have port rd_addr, output, $clog2(INPUT_SIZE), shared index into activation and weight RAMs.
REQ-011 SHALL have port act_data, input signed, WEIGHTS_WIDTH, activation read data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port wgt_data, input signed, WEIGHTS_WIDTH, weight read data, valid exactly 1 cycle after rd_en.
REQ-013 SHALL have port bias, input signed, BIAS_WIDTH, neuron bias; held stable by the caller from start until done.
REQ-014 SHALL have port acc_out, output signed, BIAS_WIDTH, saturated dot product plus bias; feeds the tanh stage inputs port.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DRAIN, BIAS, DONE.
REQ-016 IDLE: on start=1, SHALL clear the accumulator, set rd_addr=0 and rd_en=1, and enter FETCH.
REQ-017 FETCH: SHALL increment rd_addr each cycle with rd_en=1; on the cycle rd_addr=INPUT_SIZE-1 is issued, SHALL enter DRAIN next.
REQ-018 DRAIN: rd_en=0; SHALL wait for the last product to be accumulated (3 cycles), then enter BIAS.
REQ-019 Datapath pipeline SHALL be: read data registered (+1), product act_data*wgt_data registered at 2*WEIGHTS_WIDTH bits (+1), sign-extended accumulate (+1).
REQ-020 The accumulator SHALL be BIAS_WIDTH+2 bits signed; products SHALL be accumulated without wrap.
REQ-021 BIAS: SHALL add sign-extended bias, then saturate to [-2^(BIAS_WIDTH-1), 2^(BIAS_WIDTH-1)-1] into acc_out.
REQ-022 DONE: done=1 for exactly one cycle; SHALL return to IDLE next cycle.
REQ-023 done SHALL assert exactly INPUT_SIZE+5 rising edges after the edge that sampled start.
REQ-024 acc_out SHALL change only on the edge that raises done and SHALL hold its value until the next done.
REQ-025 start while busy SHALL be ignored, and no request SHALL be queued.
REQ-026 start sampled high in the DONE cycle SHALL be ignored; start in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back neurons).
REQ-027 rd_addr SHALL never exceed INPUT_SIZE-1 and SHALL NOT wrap within a computation.

Reset
REQ-028 On rst_n=0 at a clock edge, the block SHALL enter IDLE and set done=0, busy=0, rd_en=0, rd_addr=0, acc_out=0, accumulator=0 and all pipeline registers=0.
REQ-029 Reset mid-computation SHALL abort the computation; no done SHALL follow, and the next start after release SHALL compute from index 0.
REQ-030 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-031 The state enum, default widths (WEIGHTS_WIDTH, BIAS_WIDTH) and saturation min/max constants SHALL reside in shared package mnist_pkg.
REQ-032 The multiply-accumulate pipeline SHALL be one sub-module, mac_pipe (registered multiply, accumulate, clear input).
REQ-033 The block SHALL use no vendor IP; the multiply SHALL map to inferred DSP.

Verification
REQ-034 The bench SHALL cover: INPUT_SIZE=4, act={1,2,3,4}, wgt={1,1,1,1}, bias=10 -> acc_out=20, done at edge 9 after start.
REQ-035 The bench SHALL cover: INPUT_SIZE=4, act=all -128, wgt=all 127, bias=0 -> acc_out=-65024.
REQ-036 The bench SHALL cover: INPUT_SIZE=4, act=all 127, wgt=all 127, bias=32'h7FFFFFF0 -> acc_out=32'h7FFFFFFF (positive saturation); bias=32'h80000000 with negative products -> 32'h80000000.
REQ-037 The bench SHALL cover: rst_n=0 at FETCH cycle 2 -> all outputs 0 next edge, no done; new start -> correct result, rd_addr starting at 0.
REQ-038 The bench SHALL cover: start held high continuously for 3 neurons -> start pulses mid-run ignored, exactly 3 done pulses each INPUT_SIZE+6 cycles apart, correct results.
REQ-039 The bench SHALL cover: INPUT_SIZE=512 with random act/wgt/bias -> acc_out equals the reference model, and rd_addr sequence is 0..511 with no gaps.
